decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
Parametrised successor to the combinational RV32 field decoder. It decodes one instruction per cycle from fetch, generates the immediate, flags illegal opcodes and tags rd writes. Each decoded micro-op goes into a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between fetch and rename/dispatch, absorbs dispatch stalls and supports a pipeline flush on mispredict.

Parameters:
DEPTH, 4, number of micro-op entries; power of two, >= 2
XLEN, 32, width of pc and imm

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous flush; empties the queue
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction pc
out_valid  out  1  head micro-op valid
out_ready  in  1  dispatch consumes head
out_pc  out  XLEN  head pc
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_rd_valid  out  1  writes rd and rd != 0
out_alu_op  out  3  ALU op class
out_opcode  out  7  instr[6:0]
out_func3  out  3  funct3
out_func7  out  7  funct7
out_fu_alu, out_fu_mem, out_fu_br  out  1 each  functional-unit select
out_imm  out  XLEN  sign-extended immediate
out_illegal  out  1  unknown opcode
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr, rd_ptr, count = 0.
  - All storage entries cleared to 0.
  - out_valid = 0, in_ready = 1, all out_* fields = 0.
- Handshakes:
  - in_ready = (count != DEPTH); push = in_valid & in_ready.
  - out_valid = (count != 0); pop = out_valid & out_ready.
  - Both derive from registered state only, with no combinational in->out path.
- Latency: an instruction pushed at edge N appears at the head (out_valid=1) after edge N if the queue was empty. No bypass.
- Push and pop in the same cycle (count not 0): count unchanged, both pointers advance.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- out_* fields are driven combinationally from storage[rd_ptr]. When empty they show the stale entry and are don't-care; the bench must only check them when out_valid=1.
- flush=1 at an edge: wr_ptr, rd_ptr, count = 0. Any push or pop that cycle is discarded. Flush overrides everything.
- Decode is combinational on in_instr and is written into the entry at push. Fields not listed below are 0.
  - 0010011 OP-IMM: rs1, rd, alu 011, fu_alu, func3, func7=instr[31:25], I-imm.
  - 0110111 LUI: rd, alu 100, fu_alu, U-imm.
  - 0010111 AUIPC: rd, alu 101, fu_alu, U-imm.
  - 0110011 OP: rs1, rs2, rd, alu 010, fu_alu, func3, func7.
  - 0000011 LOAD: rs1, rd, alu 000, fu_mem, func3, I-imm.
  - 0100011 STORE: rs1, rs2, alu 000, fu_mem, func3, S-imm.
  - 1100011 BRANCH: rs1, rs2, alu 001, fu_br, func3, B-imm.
  - 1100111 JALR: rs1, rd, alu 110, fu_br, func3, I-imm.
  - 1101111 JAL: rd, alu 111, fu_br, J-imm.
  - Any other opcode: all fields 0 except opcode, pc and out_illegal=1. It is still enqueued so the ROB can trap.
- out_rd_valid = 1 only for LUI, AUIPC, OP-IMM, OP, LOAD, JALR and JAL when rd != 0.
- Immediates are sign-extended from instr[31] to XLEN.
  - U-imm = {instr[31:12], 12'b0}.
  - B-imm and J-imm have bit 0 = 0.
- Reset asserted mid-operation clears the queue immediately, without waiting for clk.

Test Plan:
- Reset, then push addi x5,x1,-3 (0xFFD08293) at pc 0x100 → next cycle out_valid=1, rd=5, rs1=1, alu_op=011, imm=0xFFFFFFFD, rd_valid=1, count=1.
- Push DEPTH=4 instrs with out_ready=0 → count=4, in_ready=0. A 5th push is not accepted. Pop all four → pcs come out in order, then out_valid=0.
- Full queue with out_ready=1 and in_valid=1 for 8 cycles → a steady stream with pointers wrapping, no loss or duplication, order preserved.
- Push bne x1,x2,-8 (0xFE209CE3) → fu_br=1, alu_op=001, imm=0xFFFFFFF8, rd_valid=0. Push jal x0,16 (0x0100006F) → alu_op=111, imm=16, rd_valid=0.
- Push 0xFFFFFFFF → out_illegal=1, all fu_* flags 0, rd_valid=0, opcode=7F.
- With count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0. Drop rst_n mid-stream between edges → count=0 immediately.

Source files
------------

// File: rtl/decode_queue.sv
// RV32 instruction decoder feeding a DEPTH-entry micro-op FIFO between fetch and rename/dispatch.
// Both handshakes come from registered occupancy only; flush and async reset empty the queue.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic                       out_rd_valid,
    output logic [2:0]                 out_alu_op,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_func3,
    output logic [6:0]                 out_func7,
    output logic                       out_fu_alu,
    output logic                       out_fu_mem,
    output logic                       out_fu_br,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_valid;
        logic [2:0]      alu_op;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic            fu_alu;
        logic            fu_mem;
        logic            fu_br;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } uop_t;

    uop_t             storage [DEPTH];
    uop_t             dec;
    uop_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Immediates are assembled as signed 32-bit values, then sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic uop_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        uop_t d;
        logic writes_rd;
        d         = '0;
        writes_rd = 1'b0;
        d.pc      = pc;
        d.opcode  = instr[6:0];
        case (instr[6:0])
            OPC_OP_IMM: begin
                d.rs1 = instr[19:15]; d.rd = instr[11:7];
                d.alu_op = 3'b011; d.fu_alu = 1'b1;
                d.func3 = instr[14:12]; d.func7 = instr[31:25];
                d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                writes_rd = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.rd = instr[11:7];
                d.alu_op = (instr[6:0] == OPC_LUI) ? 3'b100 : 3'b101;
                d.fu_alu = 1'b1;
                d.imm = sext32({instr[31:12], 12'b0});
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7];
                d.alu_op = 3'b010; d.fu_alu = 1'b1;
                d.func3 = instr[14:12]; d.func7 = instr[31:25];
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                d.rs1 = instr[19:15]; d.rd = instr[11:7];
                d.alu_op = 3'b000; d.fu_mem = 1'b1;
                d.func3 = instr[14:12];
                d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                d.rs1 = instr[19:15]; d.rs2 = instr[24:20];
                d.alu_op = 3'b000; d.fu_mem = 1'b1;
                d.func3 = instr[14:12];
                d.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OPC_BRANCH: begin
                d.rs1 = instr[19:15]; d.rs2 = instr[24:20];
                d.alu_op = 3'b001; d.fu_br = 1'b1;
                d.func3 = instr[14:12];
                d.imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0});
            end
            OPC_JALR: begin
                d.rs1 = instr[19:15]; d.rd = instr[11:7];
                d.alu_op = 3'b110; d.fu_br = 1'b1;
                d.func3 = instr[14:12];
                d.imm = sext32({{20{instr[31]}}, instr[31:20]});
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                d.rd = instr[11:7];
                d.alu_op = 3'b111; d.fu_br = 1'b1;
                d.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0});
                writes_rd = 1'b1;
            end
            // Unknown opcodes still travel down the pipe so the ROB can raise the trap.
            default: d.illegal = 1'b1;
        endcase
        d.rd_valid = writes_rd && (d.rd != 5'd0);
        return d;
    endfunction

    assign dec       = decode(in_instr, in_pc);
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= dec;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Head fields are stale when the queue is empty; consumers qualify them with out_valid.
    assign head         = storage[rd_ptr];
    assign out_pc       = head.pc;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_rd       = head.rd;
    assign out_rd_valid = head.rd_valid;
    assign out_alu_op   = head.alu_op;
    assign out_opcode   = head.opcode;
    assign out_func3    = head.func3;
    assign out_func7    = head.func7;
    assign out_fu_alu   = head.fu_alu;
    assign out_fu_mem   = head.fu_mem;
    assign out_fu_br    = head.fu_br;
    assign out_imm      = head.imm;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected micro-ops are queued when pushed and
// compared against the head when dispatch consumes them.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic             out_rd_valid;
    logic [2:0]       out_alu_op;
    logic [6:0]       out_opcode;
    logic [2:0]       out_func3;
    logic [6:0]       out_func7;
    logic             out_fu_alu, out_fu_mem, out_fu_br;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] count;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_valid;
        logic [2:0]  alu_op;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic        fu_alu;
        logic        fu_mem;
        logic        fu_br;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } tx_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_valid(out_rd_valid),
        .out_alu_op(out_alu_op), .out_opcode(out_opcode), .out_func3(out_func3),
        .out_func7(out_func7), .out_fu_alu(out_fu_alu), .out_fu_mem(out_fu_mem),
        .out_fu_br(out_fu_br), .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    function automatic exp_t head();
        exp_t h;
        h.pc = out_pc; h.rs1 = out_rs1; h.rs2 = out_rs2; h.rd = out_rd;
        h.rd_valid = out_rd_valid; h.alu_op = out_alu_op; h.opcode = out_opcode;
        h.func3 = out_func3; h.func7 = out_func7; h.fu_alu = out_fu_alu;
        h.fu_mem = out_fu_mem; h.fu_br = out_fu_br; h.imm = out_imm;
        h.illegal = out_illegal;
        return h;
    endfunction

    // addi rd, rs1, imm12 built from its fields, with the expected micro-op alongside
    function automatic tx_t mk_addi(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [11:0] imm12);
        tx_t t;
        t.instr      = {imm12, rs1, 3'b000, rd, 7'b0010011};
        t.e          = '0;
        t.e.pc       = pc;
        t.e.rs1      = rs1;
        t.e.rd       = rd;
        t.e.rd_valid = (rd != 5'd0);
        t.e.alu_op   = 3'b011;
        t.e.opcode   = 7'h13;
        t.e.func7    = imm12[11:5];
        t.e.fu_alu   = 1'b1;
        t.e.imm      = {{20{imm12[11]}}, imm12};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d want 0 1 0",
                     out_valid, in_ready, count);
        end
        checks++;
        if (head() !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_fields: got %h want 0", head());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        exp_t e;
        e = '0;
        e.pc = 32'h100; e.rs1 = 5'd1; e.rd = 5'd5; e.rd_valid = 1'b1; e.alu_op = 3'b011;
        e.opcode = 7'h13; e.func7 = 7'h7F; e.fu_alu = 1'b1; e.imm = 32'hFFFF_FFFD;
        in_valid = 1'b1; in_instr = 32'hFFD0_8293; in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL addi_latency: got valid=%b count=%0d want 1 1", out_valid, count);
        end
        checks++;
        if (head() !== e) begin
            failures++;
            $display("FAIL addi_fields: got %h want %h", head(), e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL addi_pop: got valid=%b count=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        tx_t t;
        int  popped = 0;
        for (int i = 0; i < DEPTH; i++) begin
            t = mk_addi(32'h200 + 32'(4*i), 5'(i + 1), 5'(i + 7), 12'(i * 100 - 150));
            in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
            sbq.push_back(t.e);
            tick();
        end
        checks++;
        if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got count=%0d ready=%b want %0d 0", count, in_ready, DEPTH);
        end
        t = mk_addi(32'h999, 5'd9, 5'd9, 12'd9);
        in_instr = t.instr; in_pc = t.e.pc;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== CNT_W'(DEPTH)) begin
            failures++;
            $display("FAIL fill_overflow: got count=%0d want %0d", count, DEPTH);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2*DEPTH && out_valid === 1'b1; k++) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL fill_extra: got pc=%h want no entry", out_pc);
            end else if (head() !== sbq[0]) begin
                failures++;
                $display("FAIL fill_order: got %h want %h", head(), sbq[0]);
            end
            if (sbq.size() != 0) void'(sbq.pop_front());
            popped++;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (popped != DEPTH || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_drain: got popped=%0d valid=%b want %0d 0", popped, out_valid, DEPTH);
        end
        sbq.delete();
    endtask

    task automatic test_stream();
        tx_t t;
        int  idx = 0;
        int  exp_cnt = 0;
        bit  acc;
        for (int i = 0; i < DEPTH; i++) begin
            t = mk_addi(32'h1000 + 32'(4*idx), 5'(idx), 5'((idx * 3) % 32), 12'(idx * 37 - 300));
            in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
            sbq.push_back(t.e);
            idx++; exp_cnt++;
            tick();
        end
        out_ready = 1'b1;
        t = mk_addi(32'h1000 + 32'(4*idx), 5'(idx), 5'((idx * 3) % 32), 12'(idx * 37 - 300));
        for (int c = 0; c < 8; c++) begin
            in_instr = t.instr; in_pc = t.e.pc;
            acc = (exp_cnt != DEPTH);
            checks++;
            if (in_ready !== acc) begin
                failures++;
                $display("FAIL stream_ready: cycle %0d got %b want %b", c, in_ready, acc);
            end
            checks++;
            if (out_valid !== 1'b1 || head() !== sbq[0]) begin
                failures++;
                $display("FAIL stream_head: cycle %0d got %h want %h", c, head(), sbq[0]);
            end
            void'(sbq.pop_front());
            exp_cnt--;
            if (acc) begin
                sbq.push_back(t.e);
                exp_cnt++; idx++;
                t = mk_addi(32'h1000 + 32'(4*idx), 5'(idx), 5'((idx * 3) % 32),
                            12'(idx * 37 - 300));
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL stream_count: got %0d want %0d", count, exp_cnt);
        end
        for (int k = 0; k < 2*DEPTH && sbq.size() != 0; k++) begin
            checks++;
            if (out_valid !== 1'b1 || head() !== sbq[0]) begin
                failures++;
                $display("FAIL stream_drain: got %h want %h", head(), sbq[0]);
            end
            void'(sbq.pop_front());
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_empty: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_decode();
        tx_t tbl[6];
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        // bne x1,x2,-8
        tbl[0].instr = 32'hFE20_9CE3;
        tbl[0].e.rs1 = 5'd1; tbl[0].e.rs2 = 5'd2; tbl[0].e.alu_op = 3'b001;
        tbl[0].e.opcode = 7'h63; tbl[0].e.func3 = 3'b001; tbl[0].e.fu_br = 1'b1;
        tbl[0].e.imm = 32'hFFFF_FFF8;
        // jal x0,16
        tbl[1].instr = 32'h0100_006F;
        tbl[1].e.alu_op = 3'b111; tbl[1].e.opcode = 7'h6F; tbl[1].e.fu_br = 1'b1;
        tbl[1].e.imm = 32'd16;
        // all-ones word: illegal
        tbl[2].instr = 32'hFFFF_FFFF;
        tbl[2].e.opcode = 7'h7F; tbl[2].e.illegal = 1'b1;
        // lui x3,0x12345
        tbl[3].instr = 32'h1234_51B7;
        tbl[3].e.rd = 5'd3; tbl[3].e.rd_valid = 1'b1; tbl[3].e.alu_op = 3'b100;
        tbl[3].e.opcode = 7'h37; tbl[3].e.fu_alu = 1'b1; tbl[3].e.imm = 32'h1234_5000;
        // sw x2,-4(x1)
        tbl[4].instr = 32'hFE20_AE23;
        tbl[4].e.rs1 = 5'd1; tbl[4].e.rs2 = 5'd2; tbl[4].e.opcode = 7'h23;
        tbl[4].e.func3 = 3'b010; tbl[4].e.fu_mem = 1'b1; tbl[4].e.imm = 32'hFFFF_FFFC;
        // sub x7,x1,x2
        tbl[5].instr = 32'h4020_83B3;
        tbl[5].e.rs1 = 5'd1; tbl[5].e.rs2 = 5'd2; tbl[5].e.rd = 5'd7;
        tbl[5].e.rd_valid = 1'b1; tbl[5].e.alu_op = 3'b010; tbl[5].e.opcode = 7'h33;
        tbl[5].e.func7 = 7'h20; tbl[5].e.fu_alu = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tbl[i].e.pc = 32'h4000 + 32'(8*i);
            in_valid = 1'b1; in_instr = tbl[i].instr; in_pc = tbl[i].e.pc;
            sbq.push_back(tbl[i].e);
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || head() !== sbq[0]) begin
                failures++;
                $display("FAIL decode_%0d: got valid=%b %h want %h", i, out_valid, head(), sbq[0]);
            end
            void'(sbq.pop_front());
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_flush();
        tx_t t;
        for (int i = 0; i < 3; i++) begin
            t = mk_addi(32'h600 + 32'(4*i), 5'(20 + i), 5'd2, 12'(i));
            in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== CNT_W'(3)) begin
            failures++;
            $display("FAIL flush_pre: got count=%0d want 3", count);
        end
        t = mk_addi(32'h700, 5'd30, 5'd3, 12'd5);
        in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: got count=%0d valid=%b ready=%b want 0 0 1",
                     count, out_valid, in_ready);
        end
        t = mk_addi(32'h800, 5'd11, 5'd12, 12'hF00);
        in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || count !== CNT_W'(1) || head() !== t.e) begin
            failures++;
            $display("FAIL flush_after: got count=%0d %h want 1 %h", count, head(), t.e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        tx_t t;
        for (int i = 0; i < 2; i++) begin
            t = mk_addi(32'h900 + 32'(4*i), 5'd4, 5'd4, 12'd4);
            in_valid = 1'b1; in_instr = t.instr; in_pc = t.e.pc;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL areset_pre: got count=%0d want 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || head() !== exp_t'(0)) begin
            failures++;
            $display("FAIL areset_now: got count=%0d valid=%b ready=%b head=%h want 0 0 1 0",
                     count, out_valid, in_ready, head());
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fill();
        test_stream();
        test_decode();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
